// File: rtl/rf_mode_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rf_mode_pkg
// Shared definitions for the RF mode sequencer:
//   - rf_mode_t   : radio mode value, bit order {M1,M0}
//   - MODE_*      : radio mode encodings
//   - rf_state_e  : sequencer FSM states (also exported on the debug port)
// -----------------------------------------------------------------------------
package rf_mode_pkg;

    typedef logic [1:0] rf_mode_t;

    localparam rf_mode_t MODE_NORMAL  = 2'b00;
    localparam rf_mode_t MODE_WAKEUP  = 2'b01;
    localparam rf_mode_t MODE_PWRSAVE = 2'b10;
    localparam rf_mode_t MODE_SLEEP   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE_WAIT = 3'd1,
        ST_APPLY    = 3'd2,
        ST_WAIT_AUX = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_DONE     = 3'd5
    } rf_state_e;

endpackage

// File: rtl/rf_mode_sequencer_if.sv
// -----------------------------------------------------------------------------
// rf_mode_sequencer_if
// Request handshake and status bundle between the transceiver control FSM
// (master) and the RF mode sequencer (slave).
//
// Handshake: a request transfers on a rising clk edge where mode_req_valid
// and mode_req_ready are both high. The master holds mode_req_valid and
// mode_req stable until that edge; mode_req_ready is high only while the
// sequencer is idle, and requests are never queued.
//
//   mode_req_valid  master->slave  request present
//   mode_req        master->slave  requested mode {M1,M0}
//   mode_req_ready  slave->master  sequencer idle, request can be taken
//   mode_cur        slave->master  last completed mode
//   busy            slave->master  sequencer not idle
//   done            slave->master  one-cycle pulse, request completed
//   timeout_err     slave->master  one-cycle pulse, AUX wait timed out
//   tx_permit       slave->master  idle and radio reports ready
// -----------------------------------------------------------------------------
interface rf_mode_sequencer_if;
    import rf_mode_pkg::*;

    logic     mode_req_valid;
    rf_mode_t mode_req;
    logic     mode_req_ready;
    rf_mode_t mode_cur;
    logic     busy;
    logic     done;
    logic     timeout_err;
    logic     tx_permit;

    modport master (
        output mode_req_valid, mode_req,
        input  mode_req_ready, mode_cur, busy, done, timeout_err, tx_permit
    );

    modport slave (
        input  mode_req_valid, mode_req,
        output mode_req_ready, mode_cur, busy, done, timeout_err, tx_permit
    );

endinterface

// File: rtl/rf_mode_sequencer_aux_ready_filter.sv
// -----------------------------------------------------------------------------
// aux_ready_filter
// Brings the asynchronous AUX pin into the clk domain with a 2-flop
// synchronizer and qualifies it with a saturating stability counter.
//
//   clk, rst_n  clock, asynchronous active-low reset
//   AUX         raw radio ready pin (asynchronous, high = ready)
//   clr         restart the stability count (used when mode pins change)
//   aux_ready   synchronized AUX has been high STABLE_CYCLES cycles in a row
// -----------------------------------------------------------------------------
module aux_ready_filter #(
    parameter int STABLE_CYCLES = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic AUX,
    input  logic clr,
    output logic aux_ready
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STABLE_CYCLES);

    logic          aux_meta;
    logic          aux_sync;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aux_meta   <= 1'b0;
            aux_sync   <= 1'b0;
            stable_cnt <= '0;
        end else begin
            aux_meta <= AUX;
            aux_sync <= aux_meta;
            // A single low sample restarts qualification; the count holds
            // at LIMIT so it never wraps back to "not ready".
            if (clr || !aux_sync) begin
                stable_cnt <= '0;
            end else if (stable_cnt != LIMIT) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign aux_ready = (stable_cnt == LIMIT);

endmodule

// File: rtl/rf_mode_sequencer.sv
// -----------------------------------------------------------------------------
// rf_mode_sequencer
// Sequences mode changes of the external RF radio: drives M0/M1, waits for the
// radio's AUX ready pin before and after switching, applies a settle delay and
// then reports the new mode. tx_permit gates UART traffic until the radio is
// in a known mode and ready.
//
// Parameters
//   AUX_STABLE_CYCLES  consecutive synchronized-high AUX samples for "ready"
//   SETTLE_CYCLES      extra wait after AUX ready before the mode is reported
//   TIMEOUT_CYCLES     max cycles per AUX wait phase (timeout build only)
//   RESET_MODE         mode driven on M0/M1 out of reset
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   ctrl         request handshake + status (rf_mode_sequencer_if.slave)
//   M0, M1       registered radio mode pins
//   AUX          radio ready pin, asynchronous
//   state_dbg    current FSM state
//
// Build option
//   RF_MODE_TIMEOUT_EN  defined: wait phases time out after TIMEOUT_CYCLES and
//                       pulse timeout_err. Undefined: waits block indefinitely
//                       and timeout_err is tied low.
// -----------------------------------------------------------------------------
module rf_mode_sequencer
    import rf_mode_pkg::*;
#(
    parameter int       AUX_STABLE_CYCLES = 100,
    parameter int       SETTLE_CYCLES     = 2000,
    parameter int       TIMEOUT_CYCLES    = 50000,
    parameter rf_mode_t RESET_MODE        = 2'b00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rf_mode_sequencer_if.slave   ctrl,
    output logic                 M0,
    output logic                 M1,
    input  logic                 AUX,
    output rf_state_e            state_dbg
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    rf_state_e        state;
    rf_mode_t         mode_nxt;
    rf_mode_t         mode_pins;
    rf_mode_t         mode_cur_q;
    logic             boot_q;     // power-up confirmation, completes without done
    logic             busy_q;
    logic             done_q;
    logic [SET_W-1:0] set_cnt;
    logic             aux_ready;
    logic             aux_clr;

`ifdef RF_MODE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_q;
    logic            to_hit;

    // High on the TIMEOUT_CYCLES-th cycle spent in a wait state.
    assign to_hit = (to_cnt >= TO_LAST);
`endif

    // Restart AUX qualification while the pins are being switched so the
    // radio's response to the new mode is what gets qualified.
    assign aux_clr = (state == ST_APPLY);

    aux_ready_filter #(
        .STABLE_CYCLES(AUX_STABLE_CYCLES)
    ) u_aux_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .AUX      (AUX),
        .clr      (aux_clr),
        .aux_ready(aux_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Power-up goes straight to WAIT_AUX so the radio is confirmed
            // ready in RESET_MODE before the first request is accepted.
            state      <= ST_WAIT_AUX;
            mode_nxt   <= RESET_MODE;
            mode_pins  <= RESET_MODE;
            mode_cur_q <= RESET_MODE;
            boot_q     <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            set_cnt    <= '0;
`ifdef RF_MODE_TIMEOUT_EN
            to_cnt     <= '0;
            to_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef RF_MODE_TIMEOUT_EN
            to_q   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    // mode_req_ready is ~busy_q, which is low only outside IDLE.
                    if (ctrl.mode_req_valid) begin
                        busy_q <= 1'b1;
                        if (ctrl.mode_req == mode_cur_q) begin
                            state <= ST_DONE;
                        end else begin
                            mode_nxt <= ctrl.mode_req;
                            state    <= ST_PRE_WAIT;
`ifdef RF_MODE_TIMEOUT_EN
                            to_cnt   <= '0;
`endif
                        end
                    end
                end

                ST_PRE_WAIT: begin
                    // Never switch the radio while it is mid-operation.
                    if (aux_ready) begin
                        state <= ST_APPLY;
                    end
`ifdef RF_MODE_TIMEOUT_EN
                    else if (to_hit) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        to_q   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                ST_APPLY: begin
                    mode_pins <= mode_nxt;
                    state     <= ST_WAIT_AUX;
`ifdef RF_MODE_TIMEOUT_EN
                    to_cnt    <= '0;
`endif
                end

                ST_WAIT_AUX: begin
                    if (aux_ready) begin
                        state   <= ST_SETTLE;
                        set_cnt <= '0;
                    end
`ifdef RF_MODE_TIMEOUT_EN
                    else if (to_hit) begin
                        // Pins already carry mode_nxt, so report it as current.
                        state      <= ST_IDLE;
                        busy_q     <= 1'b0;
                        to_q       <= 1'b1;
                        mode_cur_q <= mode_nxt;
                        boot_q     <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end

                ST_SETTLE: begin
                    // Purely time-based: AUX is not looked at here.
                    if (set_cnt >= SET_LAST) begin
                        mode_cur_q <= mode_nxt;
                        boot_q     <= 1'b0;
                        if (boot_q) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign M0                  = mode_pins[0];
    assign M1                  = mode_pins[1];
    assign ctrl.mode_cur       = mode_cur_q;
    assign ctrl.busy           = busy_q;
    assign ctrl.mode_req_ready = ~busy_q;
    assign ctrl.done           = done_q;
    assign ctrl.tx_permit      = ~busy_q & aux_ready;
`ifdef RF_MODE_TIMEOUT_EN
    assign ctrl.timeout_err    = to_q;
`else
    assign ctrl.timeout_err    = 1'b0;
`endif
    assign state_dbg           = state;

endmodule
